unidade_controle_multiciclo: RTL and testbench

Multicycle MIPS control FSM. It is the parametrised successor of the single-cycle control unit and drives a shared-memory datapath: one memory port for instructions and data, with an IR register and ALU-out register.
- Supports ADD, SUB, AND, OR, NOR, SLT, JR, LW, SW, BEQ, BNE (optional), ADDI, J and JAL.
- Adds wait-state memory handshake, bus timeout, illegal-opcode trap and a retired-instruction counter.

---
 rtl/unidade_controle_multiciclo.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// unidade_controle_multiciclo
//
// Control FSM for a multicycle MIPS datapath that shares a single memory port
// between instruction fetch and data access (IR and ALUOut registers hold the
// intermediate results between cycles).
//
// Supported: ADD, SUB, AND, OR, NOR, SLT, JR, LW, SW, BEQ, BNE (optional),
// ADDI, J, JAL. Memory accesses wait on mem_ready, with a bounded wait that
// raises bus_error and halts. Illegal instructions either halt or act as NOP.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   OP, Funct       IR[31:26] and IR[5:0]
//   mem_ready       memory completes the current access this cycle
//   mem_req, IorD, MemWrite          memory port control
//   IRWrite, PCWrite, Branch, BranchNe, PCSrc   IR / PC update control
//   RegWrite, RegDst, MemtoReg       register file write control
//   ULASrcA, ULASrcB, ULAControl     ALU operand / operation select
//   state           current state code
//   instr_done      one-cycle pulse on the transition that retires an instr
//   retired         retired-instruction counter (wraps)
//   illegal         sticky: illegal instruction seen
//   bus_error       sticky: memory wait exceeded WAIT_MAX
//
// Parameters: ULA_W (>=3, upper bits of ULAControl are 0), ENABLE_BNE,
// TRAP_ON_ILLEGAL, WAIT_MAX, CNT_W.
// -----------------------------------------------------------------------------
module unidade_controle_multiciclo #(
    parameter int ULA_W           = 3,
    parameter int ENABLE_BNE      = 1,
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int WAIT_MAX        = 15,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             BranchNe,
    output logic [1:0]       PCSrc,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             ULASrcA,
    output logic [1:0]       ULASrcB,
    output logic [ULA_W-1:0] ULAControl,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             bus_error
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Wait counter holds 0..WAIT_MAX.
    localparam int                WAIT_W     = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              illegal_q, illegal_d;
    logic              bus_error_q, bus_error_d;

    // Ungated strobes; reset masking is applied at the ports.
    logic       mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s;
    logic       branch_s, branch_ne_s, retire_s;
    logic [2:0] alu_ctl;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d     = state_q;
        wait_d      = '0;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        retire_s    = 1'b0;
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        branch_s    = 1'b0;
        branch_ne_s = 1'b0;
        IorD        = 1'b0;
        PCSrc       = 2'b00;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ULASrcA     = 1'b0;
        ULASrcB     = 2'b00;
        alu_ctl     = ALU_AND;

        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                ULASrcB   = 2'b01;
                alu_ctl   = ALU_ADD;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                ULASrcB = 2'b11;
                alu_ctl = ALU_ADD;
                case (OP)
                    OP_RTYPE: begin
                        case (Funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT:
                                state_d = S_EXEC;
                            FN_JR:
                                state_d = S_JR;
                            default: begin
                                state_d   = S_TRAP;
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_BNE: begin
                        if (ENABLE_BNE != 0) begin
                            state_d = S_BRANCH;
                        end else begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    OP_JAL:  state_d = S_JAL;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ULASrcA = 1'b1;
                ULASrcB = 2'b10;
                alu_ctl = ALU_ADD;
                state_d = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                IorD      = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg    = 2'b01;
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
                retire_s    = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                IorD        = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end
            end
            S_EXEC: begin
                ULASrcA = 1'b1;
                case (Funct)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_NOR:  alu_ctl = ALU_NOR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_AND;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst      = 2'b01;
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
                retire_s    = 1'b1;
            end
            S_BRANCH: begin
                ULASrcA     = 1'b1;
                alu_ctl     = ALU_SUB;
                PCSrc       = 2'b01;
                branch_s    = (OP == OP_BEQ);
                branch_ne_s = (OP == OP_BNE);
                state_d     = S_FETCH;
                retire_s    = 1'b1;
            end
            S_ADDIEX: begin
                ULASrcA = 1'b1;
                ULASrcB = 2'b10;
                alu_ctl = ALU_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
                retire_s    = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                pc_write_s = 1'b1;
                state_d    = S_FETCH;
                retire_s   = 1'b1;
            end
            S_JAL: begin
                RegDst      = 2'b10;
                MemtoReg    = 2'b10;
                reg_write_s = 1'b1;
                PCSrc       = 2'b10;
                pc_write_s  = 1'b1;
                state_d     = S_FETCH;
                retire_s    = 1'b1;
            end
            S_JR: begin
                PCSrc      = 2'b11;
                pc_write_s = 1'b1;
                state_d    = S_FETCH;
                retire_s   = 1'b1;
            end
            S_TRAP: begin
                // A bus error always halts; an illegal op may be a NOP.
                if (!bus_error_q && (TRAP_ON_ILLEGAL == 0)) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Shared wait-state handling for every memory state. The counter
        // falls back to 0 whenever the FSM is not stalled, so it is already
        // clear on entry to the next memory state. mem_ready is checked
        // first, so completing with the counter at WAIT_MAX is not an error.
        if (mem_req_s && !mem_ready) begin
            if (wait_q == WAIT_LIMIT) begin
                bus_error_d = 1'b1;
                state_d     = S_TRAP;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        retired_d = retire_s ? (retired_q + 1'b1) : retired_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all control state is reset; there is no storage array here
        // that could be left unreset.
        if (rst) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            retired_q   <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            retired_q   <= retired_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // The state register already reads FETCH during reset, whose decode
    // would request memory; strobes are masked so nothing fires while rst=1.
    assign mem_req    = mem_req_s   & ~rst;
    assign MemWrite   = mem_write_s & ~rst;
    assign IRWrite    = ir_write_s  & ~rst;
    assign PCWrite    = pc_write_s  & ~rst;
    assign RegWrite   = reg_write_s & ~rst;
    assign Branch     = branch_s    & ~rst;
    assign BranchNe   = branch_ne_s & ~rst;
    assign instr_done = retire_s    & ~rst;

    assign ULAControl = ULA_W'(alu_ctl);
    assign state      = state_q;
    assign retired    = retired_q;
    assign illegal    = illegal_q;
    assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// Testbench for unidade_controle_multiciclo.
// dut_a: ULA_W=4, BNE enabled, illegal op halts, 32-bit counter.
// dut_b: ULA_W=3, BNE disabled, illegal op is a NOP, 4-bit counter.
// Both share the same stimulus; each section checks one of them against a
// model that expands every instruction class into its expected state walk.
// -----------------------------------------------------------------------------
module tb_unidade_controle_multiciclo;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;

    typedef struct packed {
        logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, branchne;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic [1:0] regdst, memtoreg;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] ulac;
        logic       done;
    } outs_t;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       done;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready;
    logic [5:0] op, funct;

    logic a_mem_req, a_iord, a_memwrite, a_irwrite, a_pcwrite, a_branch, a_branchne;
    logic a_regwrite, a_srca, a_done, a_illegal, a_bus_error;
    logic [1:0] a_pcsrc, a_regdst, a_memtoreg, a_srcb;
    logic [3:0] a_ulac, a_state;
    logic [31:0] a_retired;

    logic b_mem_req, b_iord, b_memwrite, b_irwrite, b_pcwrite, b_branch, b_branchne;
    logic b_regwrite, b_srca, b_done, b_illegal, b_bus_error;
    logic [1:0] b_pcsrc, b_regdst, b_memtoreg, b_srcb;
    logic [2:0] b_ulac;
    logic [3:0] b_state;
    logic [3:0] b_retired;

    int tests = 0;
    int fails = 0;
    cyc_t plan[$];
    logic [31:0] ret_model;
    logic        ill_model;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(
        .ULA_W(4), .ENABLE_BNE(1), .TRAP_ON_ILLEGAL(1), .WAIT_MAX(15), .CNT_W(32)
    ) dut_a (
        .clk(clk), .rst(rst), .OP(op), .Funct(funct), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .IorD(a_iord), .MemWrite(a_memwrite), .IRWrite(a_irwrite),
        .PCWrite(a_pcwrite), .Branch(a_branch), .BranchNe(a_branchne), .PCSrc(a_pcsrc),
        .RegWrite(a_regwrite), .RegDst(a_regdst), .MemtoReg(a_memtoreg), .ULASrcA(a_srca),
        .ULASrcB(a_srcb), .ULAControl(a_ulac), .state(a_state), .instr_done(a_done),
        .retired(a_retired), .illegal(a_illegal), .bus_error(a_bus_error)
    );

    unidade_controle_multiciclo #(
        .ULA_W(3), .ENABLE_BNE(0), .TRAP_ON_ILLEGAL(0), .WAIT_MAX(15), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .OP(op), .Funct(funct), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .IorD(b_iord), .MemWrite(b_memwrite), .IRWrite(b_irwrite),
        .PCWrite(b_pcwrite), .Branch(b_branch), .BranchNe(b_branchne), .PCSrc(b_pcsrc),
        .RegWrite(b_regwrite), .RegDst(b_regdst), .MemtoReg(b_memtoreg), .ULASrcA(b_srca),
        .ULASrcB(b_srcb), .ULAControl(b_ulac), .state(b_state), .instr_done(b_done),
        .retired(b_retired), .illegal(b_illegal), .bus_error(b_bus_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input outs_t got, input outs_t exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s outputs: got %06h expected %06h", tag, got, exp);
        end
    endtask

    function automatic outs_t get_outs(input bit sel);
        outs_t o;
        if (sel) begin
            o.mem_req = b_mem_req; o.iord = b_iord; o.memwrite = b_memwrite;
            o.irwrite = b_irwrite; o.pcwrite = b_pcwrite; o.branch = b_branch;
            o.branchne = b_branchne; o.pcsrc = b_pcsrc; o.regwrite = b_regwrite;
            o.regdst = b_regdst; o.memtoreg = b_memtoreg; o.srca = b_srca;
            o.srcb = b_srcb; o.ulac = {1'b0, b_ulac}; o.done = b_done;
        end else begin
            o.mem_req = a_mem_req; o.iord = a_iord; o.memwrite = a_memwrite;
            o.irwrite = a_irwrite; o.pcwrite = a_pcwrite; o.branch = a_branch;
            o.branchne = a_branchne; o.pcsrc = a_pcsrc; o.regwrite = a_regwrite;
            o.regdst = a_regdst; o.memtoreg = a_memtoreg; o.srca = a_srca;
            o.srcb = a_srcb; o.ulac = a_ulac; o.done = a_done;
        end
        return o;
    endfunction

    function automatic logic [31:0] get_state(input bit sel);
        return sel ? {28'd0, b_state} : {28'd0, a_state};
    endfunction
    function automatic logic [31:0] get_retired(input bit sel);
        return sel ? {28'd0, b_retired} : a_retired;
    endfunction
    function automatic logic [31:0] get_flags(input bit sel);
        return sel ? {30'd0, b_illegal, b_bus_error} : {30'd0, a_illegal, a_bus_error};
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            F_ADD:   return 4'b0010;
            F_SUB:   return 4'b0110;
            F_OR:    return 4'b0001;
            F_NOR:   return 4'b0011;
            F_SLT:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    // Expected control word for one cycle, straight from the state table.
    function automatic outs_t exp_outs(input logic [3:0] st, input logic [5:0] op_i,
                                       input logic [5:0] fn_i, input logic rdy,
                                       input logic done);
        outs_t o = '0;
        case (st)
            4'd0:  begin o.mem_req = 1; o.srcb = 2'b01; o.ulac = 4'd2; o.irwrite = rdy; o.pcwrite = rdy; end
            4'd1:  begin o.srcb = 2'b11; o.ulac = 4'd2; end
            4'd2:  begin o.srca = 1; o.srcb = 2'b10; o.ulac = 4'd2; end
            4'd3:  begin o.mem_req = 1; o.iord = 1; end
            4'd4:  begin o.memtoreg = 2'b01; o.regwrite = 1; end
            4'd5:  begin o.mem_req = 1; o.iord = 1; o.memwrite = 1; end
            4'd6:  begin o.srca = 1; o.ulac = alu_of(fn_i); end
            4'd7:  begin o.regdst = 2'b01; o.regwrite = 1; end
            4'd8:  begin o.srca = 1; o.ulac = 4'd6; o.pcsrc = 2'b01;
                         o.branch = (op_i == OP_BEQ); o.branchne = (op_i == OP_BNE); end
            4'd9:  begin o.srca = 1; o.srcb = 2'b10; o.ulac = 4'd2; end
            4'd10: begin o.regwrite = 1; end
            4'd11: begin o.pcsrc = 2'b10; o.pcwrite = 1; end
            4'd12: begin o.regdst = 2'b10; o.memtoreg = 2'b10; o.regwrite = 1;
                         o.pcsrc = 2'b10; o.pcwrite = 1; end
            4'd13: begin o.pcsrc = 2'b11; o.pcwrite = 1; end
            default: ;
        endcase
        o.done = done;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic [3:0] st, input logic rdy, input logic done);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.done = done;
        plan.push_back(c);
    endtask

    // Expands one instruction into its cycle-by-cycle walk. fw/mw are the
    // wait cycles inserted before mem_ready in FETCH / the data access.
    task automatic build_plan(input bit sel, input logic [5:0] op_i, input logic [5:0] fn_i,
                              input int fw, input int mw);
        bit alu_fn;
        alu_fn = (fn_i == F_ADD) || (fn_i == F_SUB) || (fn_i == F_AND) ||
                 (fn_i == F_OR) || (fn_i == F_NOR) || (fn_i == F_SLT);
        plan.delete();
        for (int i = 0; i < fw; i++) add(4'd0, 1'b0, 1'b0);
        add(4'd0, 1'b1, 1'b0);
        add(4'd1, rb(), 1'b0);
        if (op_i == OP_R && fn_i == F_JR) add(4'd13, rb(), 1'b1);
        else if (op_i == OP_R && alu_fn) begin add(4'd6, rb(), 1'b0); add(4'd7, rb(), 1'b1); end
        else if (op_i == OP_LW) begin
            add(4'd2, rb(), 1'b0);
            for (int i = 0; i < mw; i++) add(4'd3, 1'b0, 1'b0);
            add(4'd3, 1'b1, 1'b0);
            add(4'd4, rb(), 1'b1);
        end else if (op_i == OP_SW) begin
            add(4'd2, rb(), 1'b0);
            for (int i = 0; i < mw; i++) add(4'd5, 1'b0, 1'b0);
            add(4'd5, 1'b1, 1'b1);
        end else if (op_i == OP_BEQ || (op_i == OP_BNE && !sel)) add(4'd8, rb(), 1'b1);
        else if (op_i == OP_ADDI) begin add(4'd9, rb(), 1'b0); add(4'd10, rb(), 1'b1); end
        else if (op_i == OP_J) add(4'd11, rb(), 1'b1);
        else if (op_i == OP_JAL) add(4'd12, rb(), 1'b1);
        else add(4'd14, rb(), sel);   // dut_b treats illegal as a retiring NOP
    endtask

    // Called at posedge+1; drives each planned cycle, checks at the negedge.
    task automatic exec_plan(input bit sel, input int n, input string tag);
        for (int i = 0; i < n && i < plan.size(); i++) begin
            mem_ready = plan[i].rdy;
            @(negedge clk);
            check($sformatf("%s c%0d state", tag, i), get_state(sel), {28'd0, plan[i].st});
            check_outs($sformatf("%s c%0d", tag, i), get_outs(sel),
                       exp_outs(plan[i].st, op, funct, plan[i].rdy, plan[i].done));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input bit sel, input logic [5:0] op_i, input logic [5:0] fn_i,
                             input int fw, input int mw, input string tag);
        op = op_i;
        funct = fn_i;
        build_plan(sel, op_i, fn_i, fw, mw);
        exec_plan(sel, plan.size(), tag);
        if (plan[plan.size()-1].st == 4'd14) ill_model = 1'b1;
        if (plan[plan.size()-1].done) ret_model = sel ? ((ret_model + 1) & 32'hF) : ret_model + 1;
        check({tag, " retired"}, get_retired(sel), ret_model);
        check({tag, " flags"}, get_flags(sel), {30'd0, ill_model, 1'b0});
    endtask

    // Asserts reset away from a clock edge and checks the forced state of
    // both instances before releasing it at posedge+1.
    task automatic do_reset(input string tag);
        outs_t e;
        rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            e = exp_outs(4'd0, op, funct, mem_ready, 1'b0);
            e.mem_req = 0; e.memwrite = 0; e.irwrite = 0; e.pcwrite = 0;
            e.regwrite = 0; e.branch = 0; e.branchne = 0;
            if (s == 1) e.ulac[3] = 1'b0;
            check($sformatf("%s rst%0d state", tag, s), get_state(s[0]), 32'd0);
            check_outs($sformatf("%s rst%0d", tag, s), get_outs(s[0]), e);
            check($sformatf("%s rst%0d retired", tag, s), get_retired(s[0]), 32'd0);
            check($sformatf("%s rst%0d flags", tag, s), get_flags(s[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ret_model = '0;
        ill_model = 1'b0;
    endtask

    initial begin
        logic [5:0] ops[9];
        logic [5:0] fns[9];
        logic [5:0] alu_fns[6];
        int k;

        ops = '{OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL};
        fns = '{F_ADD, F_JR, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        alu_fns = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};

        rst = 1'b1;
        mem_ready = 1'b0;
        op = OP_R;
        funct = F_ADD;
        #2;
        do_reset("init");

        // First cycle after reset release with mem_ready=1, then ADD.
        run_instr(0, OP_R, F_ADD, 0, 0, "add");
        run_instr(0, OP_LW, 6'd0, 0, 3, "lw_w3");
        run_instr(0, OP_BNE, 6'd0, 1, 0, "bne_a");
        run_instr(0, OP_SW, 6'd0, 2, 2, "sw_w2");

        // Reset while stalled in MEMREAD.
        op = OP_LW;
        funct = 6'd0;
        build_plan(0, OP_LW, 6'd0, 0, 2);
        exec_plan(0, 4, "lw_part");
        mem_ready = 1'b0;
        #2;
        check("mid_memread state", get_state(0), 32'd3);
        do_reset("mid_memread");
        run_instr(0, OP_R, F_ADD, 0, 0, "add_after_rst");

        // Longest legal waits: mem_ready arrives with the counter at WAIT_MAX.
        run_instr(0, OP_R, F_SUB, 15, 0, "fetch_w15");
        run_instr(0, OP_LW, 6'd0, 0, 15, "lw_w15");
        run_instr(0, OP_SW, 6'd0, 14, 15, "sw_w15");

        // Randomized instruction stream on dut_a.
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 8);
            funct = (k == 0) ? alu_fns[$urandom_range(0, 5)] : fns[k];
            run_instr(0, ops[k], funct, $urandom_range(0, 3), $urandom_range(0, 3),
                      $sformatf("rnd%0d", n));
        end

        // Bus timeout in FETCH: 15 counted waits, error on the 16th stall.
        do_reset("pre_buserr");
        op = OP_R;
        funct = F_ADD;
        for (int i = 0; i < 16; i++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            check($sformatf("buserr w%0d state", i), get_state(0), 32'd0);
            check_outs($sformatf("buserr w%0d", i), get_outs(0), exp_outs(4'd0, op, funct, 1'b0, 1'b0));
            check($sformatf("buserr w%0d flags", i), get_flags(0), 32'd0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            mem_ready = rb();
            @(negedge clk);
            check($sformatf("trap_be%0d state", i), get_state(0), 32'd14);
            check_outs($sformatf("trap_be%0d", i), get_outs(0), exp_outs(4'd14, op, funct, 1'b0, 1'b0));
            check($sformatf("trap_be%0d flags", i), get_flags(0), 32'd1);
            @(posedge clk);
            #1;
        end

        // Illegal opcode on dut_a halts in TRAP.
        do_reset("pre_ill");
        run_instr(0, OP_R, F_OR, 0, 0, "or_pre_ill");
        run_instr(0, 6'b111111, 6'd0, 0, 0, "ill_op");
        for (int i = 0; i < 3; i++) begin
            mem_ready = rb();
            @(negedge clk);
            check($sformatf("ill_halt%0d state", i), get_state(0), 32'd14);
            check($sformatf("ill_halt%0d retired", i), get_retired(0), 32'd1);
            @(posedge clk);
            #1;
        end
        do_reset("pre_ill_fn");
        run_instr(0, OP_R, 6'b000001, 0, 0, "ill_funct");

        // dut_b: BNE is illegal and retires as NOP; then the counter wraps.
        do_reset("pre_b");
        run_instr(1, OP_BNE, 6'd0, 0, 0, "bne_b");
        for (int n = 0; n < 14; n++) begin
            k = $urandom_range(0, 8);
            if (k == 5) k = 4;
            funct = (k == 0) ? alu_fns[$urandom_range(0, 5)] : fns[k];
            run_instr(1, ops[k], funct, $urandom_range(0, 2), $urandom_range(0, 2),
                      $sformatf("b_rnd%0d", n));
        end
        check("b_full retired", get_retired(1), 32'd15);
        run_instr(1, OP_JAL, 6'd0, 0, 0, "b_jal_wrap");
        check("b_wrap retired", get_retired(1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
